// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch sequencer driving an external PC register.
// It fetches from instruction memory, holds each instruction for decode,
// and computes the next PC (sequential, redirect or hold). It stops on
// halt, on a fetch timeout, or on a misaligned redirect target.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   run              leave IDLE and start fetching
//   pc_q             current value of the external PC register
//   next_pc          value the external PC register loads every edge
//   imem_req/addr    instruction-memory read request and address
//   imem_ready/rdata memory response and instruction word
//   instr/instr_valid latched instruction and its valid flag
//   instr_ack        decode consumes instr (only honoured in HOLD)
//   redirect_valid/pc taken-branch target, sampled with an accepted ack
//   halt             stop after the acknowledged instruction
//   state            FSM state: 00 IDLE, 01 FETCH, 10 HOLD, 11 STOP
//   fault/fault_cause sticky fault; 01 fetch timeout, 10 misaligned redirect
//   instr_count      number of accepted acks (wraps)
module pc_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] pc_q,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [1:0]  state,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        STOP  = 2'b11
    } state_t;

    // Wait counter holds the number of FETCH cycles already spent without
    // ready; reaching TIMEOUT-1 in a cycle that still lacks ready means
    // TIMEOUT cycles have elapsed.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      cur_state, nxt_state;
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic [31:0] instr_d, count_d;
    logic        fault_d;
    logic [1:0]  cause_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            wait_cnt    <= '0;
            instr       <= '0;
            instr_count <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            cur_state   <= nxt_state;
            wait_cnt    <= wait_cnt_d;
            instr       <= instr_d;
            instr_count <= count_d;
            fault       <= fault_d;
            fault_cause <= cause_d;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        wait_cnt_d  = wait_cnt;
        instr_d     = instr;
        count_d     = instr_count;
        fault_d     = fault;
        cause_d     = fault_cause;
        next_pc     = pc_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        imem_addr   = pc_q;

        case (cur_state)
            IDLE: begin
                wait_cnt_d = '0;
                if (run) nxt_state = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = '0;
                    nxt_state  = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    fault_d    = 1'b1;
                    cause_d    = 2'b01;
                    nxt_state  = STOP;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                wait_cnt_d  = '0;
                if (instr_ack) begin
                    count_d = instr_count + 32'd1;
                    // Misaligned redirect wins over halt and leaves the PC held.
                    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                        fault_d   = 1'b1;
                        cause_d   = 2'b10;
                        nxt_state = STOP;
                    end else begin
                        next_pc   = redirect_valid ? redirect_pc : pc_q + 32'd4;
                        nxt_state = halt ? STOP : FETCH;
                    end
                end
            end
            STOP: begin
                wait_cnt_d = '0;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: table-driven cycle vectors compared through an
// expected-value queue, plus hand-written asynchronous reset sequences.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [1:0]  state;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .run(run), .pc_q(pc_q), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .state(state), .fault(fault),
        .fault_cause(fault_cause), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register: zeroes on reset, loads next_pc every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= next_pc;
    end

    typedef struct {
        logic        run, ready;
        logic [31:0] rdata;
        logic        ack, rv;
        logic [31:0] rpc;
        logic        halt;
        logic [1:0]  st;
        logic [31:0] npc;
        logic        req, val;
        logic [31:0] ins, cnt;
        logic [1:0]  cause;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic r, logic rdy, logic [31:0] rd, logic a,
                                logic rv, logic [31:0] rpc, logic h,
                                logic [1:0] st, logic [31:0] npc, logic req,
                                logic val, logic [31:0] ins, logic [31:0] cnt,
                                logic [1:0] cause);
        vec_t v;
        v.run = r; v.ready = rdy; v.rdata = rd; v.ack = a; v.rv = rv;
        v.rpc = rpc; v.halt = h; v.st = st; v.npc = npc; v.req = req;
        v.val = val; v.ins = ins; v.cnt = cnt; v.cause = cause;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's inputs, queues its expectation, and compares on the
    // falling edge; returns #1 after the following rising edge.
    task automatic apply(input vec_t v);
        vec_t e;
        run = v.run; imem_ready = v.ready; imem_rdata = v.rdata;
        instr_ack = v.ack; redirect_valid = v.rv; redirect_pc = v.rpc;
        halt = v.halt;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("next_pc", next_pc, e.npc);
        chk("imem_req", 32'(imem_req), 32'(e.req));
        if (e.req) chk("imem_addr", imem_addr, e.npc);
        chk("instr_valid", 32'(instr_valid), 32'(e.val));
        chk("instr", instr, e.ins);
        chk("instr_count", instr_count, e.cnt);
        chk("fault", 32'(fault), 32'(e.cause != 2'b00));
        chk("fault_cause", 32'(fault_cause), 32'(e.cause));
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 0; imem_ready = 0; imem_rdata = '0; instr_ack = 0;
        redirect_valid = 0; redirect_pc = '0; halt = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Sequential fetch, redirect, ignored ack, misaligned redirect with halt.
        do_reset();
        tbl.push_back(mk(1,0,0,     0,0,0,0,    2'd0,32'h0, 0,0,0,    0,2'd0));
        tbl.push_back(mk(0,1,32'hA0,0,0,0,0,    2'd1,32'h0, 1,0,0,    0,2'd0));
        tbl.push_back(mk(0,0,0,     1,0,0,0,    2'd2,32'h4, 0,1,32'hA0,0,2'd0));
        tbl.push_back(mk(0,1,32'hA1,0,0,0,0,    2'd1,32'h4, 1,0,32'hA0,1,2'd0));
        tbl.push_back(mk(0,0,0,     1,0,0,0,    2'd2,32'h8, 0,1,32'hA1,1,2'd0));
        tbl.push_back(mk(0,1,32'hA2,0,0,0,0,    2'd1,32'h8, 1,0,32'hA1,2,2'd0));
        tbl.push_back(mk(0,0,0,     1,1,32'h40,0,2'd2,32'h40,0,1,32'hA2,2,2'd0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,    2'd1,32'h40,1,0,32'hA2,3,2'd0));
        tbl.push_back(mk(0,1,32'hA3,1,0,0,0,    2'd1,32'h40,1,0,32'hA2,3,2'd0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,    2'd2,32'h40,0,1,32'hA3,3,2'd0));
        tbl.push_back(mk(0,0,0,     1,1,32'h42,1,2'd2,32'h40,0,1,32'hA3,3,2'd0));
        tbl.push_back(mk(1,0,0,     0,0,0,0,    2'd3,32'h40,0,0,32'hA3,4,2'd2));
        tbl.push_back(mk(1,1,0,     1,0,0,0,    2'd3,32'h40,0,0,32'hA3,4,2'd2));
        run_tbl();

        // Fetch timeout: 16 FETCH cycles without ready.
        do_reset();
        tbl.push_back(mk(1,0,0,0,0,0,0, 2'd0,0,0,0,0,0,2'd0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0, 2'd1,0,1,0,0,0,2'd0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 2'd3,0,0,0,0,0,2'd1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 2'd3,0,0,0,0,0,2'd1));
        run_tbl();

        // Ready on the 16th FETCH cycle succeeds.
        do_reset();
        tbl.push_back(mk(1,0,0,0,0,0,0, 2'd0,0,0,0,0,0,2'd0));
        for (int i = 0; i < 15; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0, 2'd1,0,1,0,0,0,2'd0));
        tbl.push_back(mk(0,1,32'h55,0,0,0,0, 2'd1,0,1,0,0,0,2'd0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 2'd2,0,0,1,32'h55,0,2'd0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 2'd2,0,0,1,32'h55,0,2'd0));
        run_tbl();

        // PC wrap at 0xFFFFFFFC, then halt; run ignored in STOP.
        do_reset();
        tbl.push_back(mk(1,0,0,     0,0,0,0,           2'd0,0,0,0,0,0,2'd0));
        tbl.push_back(mk(0,1,32'h21,0,0,0,0,           2'd1,0,1,0,0,0,2'd0));
        tbl.push_back(mk(0,0,0,     1,1,32'hFFFFFFFC,0,2'd2,32'hFFFFFFFC,0,1,32'h21,0,2'd0));
        tbl.push_back(mk(0,1,32'h22,0,0,0,0,           2'd1,32'hFFFFFFFC,1,0,32'h21,1,2'd0));
        tbl.push_back(mk(0,0,0,     1,0,0,0,           2'd2,32'h0,0,1,32'h22,1,2'd0));
        tbl.push_back(mk(0,1,32'h23,0,0,0,0,           2'd1,32'h0,1,0,32'h22,2,2'd0));
        tbl.push_back(mk(0,0,0,     1,0,0,1,           2'd2,32'h4,0,1,32'h23,2,2'd0));
        tbl.push_back(mk(1,1,0,     0,0,0,0,           2'd3,32'h4,0,0,32'h23,3,2'd0));
        tbl.push_back(mk(1,1,0,     1,0,0,0,           2'd3,32'h4,0,0,32'h23,3,2'd0));
        run_tbl();

        // Asynchronous reset mid-FETCH (after one accepted instruction).
        do_reset();
        tbl.push_back(mk(1,0,0,     0,0,0,0, 2'd0,0,0,0,0,0,2'd0));
        tbl.push_back(mk(0,1,32'h11,0,0,0,0, 2'd1,0,1,0,0,0,2'd0));
        tbl.push_back(mk(0,0,0,     1,0,0,0, 2'd2,32'h4,0,1,32'h11,0,2'd0));
        run_tbl();
        imem_ready = 0; instr_ack = 0; run = 0;
        #2;
        chk("pre_reset_fetch_req", 32'(imem_req), 32'd1);
        chk("pre_reset_count", instr_count, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_fetch_req", 32'(imem_req), 32'd0);
        chk("async_fetch_state", 32'(state), 32'd0);
        chk("async_fetch_count", instr_count, 32'd0);
        chk("async_fetch_instr", instr, 32'd0);
        chk("async_fetch_next_pc", next_pc, pc_q);
        chk("async_fetch_pc", pc_q, 32'd0);

        // Asynchronous reset mid-HOLD.
        @(posedge clk);
        #1 reset = 1'b0;
        tbl.push_back(mk(1,0,0,     0,0,0,0, 2'd0,0,0,0,0,0,2'd0));
        tbl.push_back(mk(0,1,32'h77,0,0,0,0, 2'd1,0,1,0,0,0,2'd0));
        run_tbl();
        imem_ready = 0; run = 0;
        #2;
        chk("pre_reset_hold_valid", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_hold_valid", 32'(instr_valid), 32'd0);
        chk("async_hold_state", 32'(state), 32'd0);
        chk("async_hold_instr", instr, 32'd0);
        chk("async_hold_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles in FETCH awaiting imem_ready before fault (range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port run  input  1  start fetching from IDLE.
REQ-005 SHALL have port pc_q  input  32  current value of the external PC register.
REQ-006 SHALL have port next_pc  output  32  value loaded into the external PC register every clk edge.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  32  instruction-memory read address.
REQ-009 SHALL have port imem_ready  input  1  memory returns data this cycle.
REQ-010 SHALL have port imem_rdata  input  32  instruction word, valid with imem_ready.
REQ-011 SHALL have port instr  output  32  latched instruction for decode.
REQ-012 SHALL have port instr_valid  output  1  instr holds an unconsumed instruction.
REQ-013 SHALL have port instr_ack  input  1  decode consumes instr this cycle.
REQ-014 SHALL have port redirect_valid  input  1  taken branch/jump/jr; sampled only with an accepted ack.
REQ-015 SHALL have port redirect_pc  input  32  redirect target.
REQ-016 SHALL have port halt  input  1  stop after the acknowledged instruction.
REQ-017 SHALL have port state  output  2  encoded FSM state.
REQ-018 SHALL have port fault  output  1  sticky fault flag.
REQ-019 SHALL have port fault_cause  output  2  00 none, 01 fetch timeout, 10 misaligned redirect.
REQ-020 SHALL have port instr_count  output  32  number of accepted acks.

Function
REQ-021 SHALL implement states IDLE=00, FETCH=01, HOLD=10, STOP=11; STOP covers both halt and fault, distinguished by fault.
REQ-022 SHALL drive next_pc = pc_q (hold) in every cycle except an accepted ack in HOLD.
REQ-023 IDLE: run=1 -> FETCH next cycle; else stay; imem_req=0, instr_valid=0.
REQ-024 FETCH: imem_req=1, imem_addr=pc_q; on imem_ready latch instr<=imem_rdata and go HOLD.
REQ-025 FETCH: wait counter resets on FETCH entry, increments each cycle without imem_ready; if TIMEOUT cycles elapse with no ready -> STOP, fault=1, fault_cause=01; ready on cycle TIMEOUT itself counts as success.
REQ-026 HOLD: instr_valid=1, imem_req=0, instr stable until ack.
REQ-027 Accepted ack = HOLD and instr_ack=1; instr_ack outside HOLD SHALL be ignored.
REQ-028 On accepted ack: instr_count+1 (32-bit wrap 0xFFFFFFFF->0); next_pc = redirect_valid ? redirect_pc : pc_q+4, 32-bit wrap (0xFFFFFFFC+4=0).
REQ-029 On accepted ack with redirect_valid=1 and redirect_pc[1:0]!=00: next_pc=pc_q, instr_count still increments, -> STOP, fault=1, fault_cause=10.
REQ-030 On accepted ack with halt=1 (and no fault): next_pc updated per REQ-028, -> STOP, fault=0; else -> FETCH.
REQ-031 Misaligned-redirect fault SHALL take priority over halt in the same cycle.
REQ-032 STOP SHALL be left only by reset; imem_req=0, instr_valid=0, run ignored.
REQ-033 Minimum loop: FETCH(ready same cycle) -> HOLD(ack same cycle) -> FETCH = 2 cycles per instruction.

Reset
REQ-034 Reset SHALL asynchronously force state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_count=0, fault=0, fault_cause=00, wait counter=0, at any state including mid-FETCH.
REQ-035 During reset next_pc SHALL equal pc_q; the external PC zeroes itself.

Verification
REQ-036 reset, pc_q=0, run=1, imem_ready=1 each FETCH, ack each HOLD -> imem_addr 0,4,8; instr_count=3 after third ack.
REQ-037 ack with redirect_valid=1, redirect_pc=0x40 -> next_pc=0x40, next imem_addr=0x40; with redirect_pc=0x42 -> state=STOP, fault_cause=10, next_pc=pc_q.
REQ-038 imem_ready held 0, TIMEOUT=16 -> STOP after 16 FETCH cycles, fault_cause=01; ready on 16th cycle -> HOLD, no fault.
REQ-039 pc_q=0xFFFFFFFC, ack without redirect -> next_pc=0x00000000; ack with halt=1 -> STOP, fault=0, run ignored.
REQ-040 reset asserted mid-FETCH and mid-HOLD -> imem_req, instr_valid drop same cycle asynchronously; state=IDLE, instr_count=0.
